// File: rtl/shift_operand_sequencer_pkg.sv
// Shared types and operand-2 field positions for the ARM operand-2 shift sequencer.
package shift_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned OP2_RS_LSB   = 8;  // Rs / rotate field [11:8]
  localparam int unsigned OP2_AMT_LSB  = 7;  // immediate shift amount [11:7]
  localparam int unsigned OP2_TYPE_LSB = 5;  // shift type [6:5]
  localparam int unsigned OP2_REGSH    = 4;  // register-specified shift flag

endpackage

// File: rtl/shift_operand_sequencer_shift_core.sv
// Combinational ARM operand-2 barrel shifter: result and shifter carry-out.
module shift_core
  import shift_operand_sequencer_pkg::*;
(
  input  logic        imm,
  input  logic        reg_shift,
  input  shift_t      sh_type,
  input  logic [7:0]  amount,
  input  logic [3:0]  rot,
  input  logic [7:0]  imm8,
  input  logic [31:0] rm,
  input  logic        cin,
  output logic [31:0] data,
  output logic        carry
);

  logic [4:0]  sh;
  logic [4:0]  rot2;
  logic [31:0] imm32;
  logic [31:0] rot_imm;
  logic [31:0] ror_w;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic        big;

  assign sh      = amount[4:0];
  assign rot2    = {rot, 1'b0};
  assign imm32   = {24'b0, imm8};
  assign rot_imm = (imm32 >> rot2) | (imm32 << (6'd32 - {1'b0, rot2}));
  assign ror_w   = (rm >> sh) | (rm << (6'd32 - {1'b0, sh}));
  // Extra guard bit on each shift catches the last bit shifted out as carry.
  assign lsl_w   = {1'b0, rm} << sh;
  assign lsr_w   = {rm, 1'b0} >> sh;
  assign asr_w   = $signed({rm, 1'b0}) >>> sh;
  assign big     = |amount[7:5];

  always_comb begin
    data  = rm;
    carry = cin;
    if (imm) begin
      data  = rot_imm;
      carry = (rot == 4'd0) ? cin : rot_imm[31];
    end else if (!reg_shift) begin
      unique case (sh_type)
        SH_LSL: if (sh != 5'd0) {carry, data} = lsl_w;
        SH_LSR: if (sh == 5'd0) begin data = '0; carry = rm[31]; end
                else {data, carry} = lsr_w;
        SH_ASR: if (sh == 5'd0) begin data = {32{rm[31]}}; carry = rm[31]; end
                else {data, carry} = asr_w;
        SH_ROR: if (sh == 5'd0) begin data = {cin, rm[31:1]}; carry = rm[0]; end
                else begin data = ror_w; carry = ror_w[31]; end
      endcase
    end else if (amount != 8'd0) begin
      unique case (sh_type)
        SH_LSL: if (!big) {carry, data} = lsl_w;
                else begin data = '0; carry = (amount == 8'd32) ? rm[0] : 1'b0; end
        SH_LSR: if (!big) {data, carry} = lsr_w;
                else begin data = '0; carry = (amount == 8'd32) ? rm[31] : 1'b0; end
        SH_ASR: if (!big) {data, carry} = asr_w;
                else begin data = {32{rm[31]}}; carry = rm[31]; end
        SH_ROR: if (sh == 5'd0) begin data = rm; carry = rm[31]; end
                else begin data = ror_w; carry = ror_w[31]; end
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_sequencer.sv
// Operand-2 sequencer: accepts a request, fetches Rs if needed, and hands the shifted operand to the ALU.
module shift_operand_sequencer
  import shift_operand_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_imm,
  input  logic [11:0]       req_op2,
  input  logic [DATA_W-1:0] req_rm,
  input  logic              req_cin,
  output logic              rs_rd_en,
  output logic [REG_AW-1:0] rs_rd_addr,
  input  logic              rs_rd_gnt,
  input  logic [DATA_W-1:0] rs_rd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry
);

  state_t            state, state_nxt;
  logic              accept;
  logic              req_regsh;
  logic [11:0]       op2_q;
  logic              imm_q;
  logic [DATA_W-1:0] rm_q;
  logic              cin_q;
  logic [7:0]        amt_q;
  logic              regsh_q;
  logic [7:0]        core_amt;
  logic [31:0]       core_data;
  logic              core_carry;
  logic              unused_rs_hi;

  assign req_ready    = (state == ST_IDLE) || (state == ST_DONE && res_ready);
  assign accept       = req_valid && req_ready && !flush;
  assign req_regsh    = !req_imm && req_op2[OP2_REGSH];
  assign regsh_q      = !imm_q && op2_q[OP2_REGSH];
  assign core_amt     = regsh_q ? amt_q : {3'b0, op2_q[OP2_AMT_LSB +: 5]};
  assign unused_rs_hi = ^rs_rd_data[DATA_W-1:8];

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (accept) state_nxt = req_regsh ? ST_FETCH : ST_EXEC;
        ST_FETCH: if (rs_rd_gnt) state_nxt = ST_EXEC;
        ST_EXEC:  state_nxt = ST_DONE;
        ST_DONE:  if (res_ready) state_nxt = accept ? (req_regsh ? ST_FETCH : ST_EXEC) : ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op2_q      <= '0;
      imm_q      <= 1'b0;
      rm_q       <= '0;
      cin_q      <= 1'b0;
      amt_q      <= '0;
      rs_rd_en   <= 1'b0;
      rs_rd_addr <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_carry  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op2_q <= req_op2;
        imm_q <= req_imm;
        rm_q  <= req_rm;
        cin_q <= req_cin;
      end
      if (flush) begin
        rs_rd_en  <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        if (accept && req_regsh) begin
          rs_rd_en   <= 1'b1;
          rs_rd_addr <= req_op2[OP2_RS_LSB +: REG_AW];
        end else if (state == ST_FETCH && rs_rd_gnt) begin
          rs_rd_en <= 1'b0;
          amt_q    <= rs_rd_data[7:0];
        end
        if (state == ST_EXEC) begin
          res_valid <= 1'b1;
          res_data  <= core_data;
          res_carry <= core_carry;
        end else if (state == ST_DONE && res_ready) begin
          res_valid <= 1'b0;
        end
      end
    end
  end

  shift_core u_shift_core (
    .imm       (imm_q),
    .reg_shift (regsh_q),
    .sh_type   (shift_t'(op2_q[OP2_TYPE_LSB +: 2])),
    .amount    (core_amt),
    .rot       (op2_q[OP2_RS_LSB +: 4]),
    .imm8      (op2_q[7:0]),
    .rm        (rm_q),
    .cin       (cin_q),
    .data      (core_data),
    .carry     (core_carry)
  );

endmodule
